// File: rtl/layer_mem_arbiter_if.sv
// Requester-side bus of the layer-memory arbiter: three requesters packed by index.
interface layer_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 20
);
    logic [2:0]         valid;
    logic [2:0]         we;
    logic [2:0][2:0]    sel;
    logic [2:0][AW-1:0] addr;
    logic [2:0][DW-1:0] wdata;
    logic [2:0]         ready;
    logic [2:0]         rvalid;
    logic [DW-1:0]      rdata;

    modport master (
        output valid, we, sel, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, sel, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing one layer-memory port among three engines, with
// registered memory strobes and a 2-stage read tag pipeline returning data to its owner.
module layer_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 20
) (
    input  logic                clk,
    input  logic                rst,
    layer_mem_arbiter_if.slave  req_if,
    output logic                crd_o,
    output logic [AW-1:0]       caddr_rd_o,
    output logic                cwr_o,
    output logic [AW-1:0]       caddr_wr_o,
    output logic [DW-1:0]       cdata_wr_o,
    output logic [2:0]          csel_o,
    input  logic [DW-1:0]       cdata_rd_i,
    output logic                idle_o
);

    // Returns {found, id}: first valid requester in order ptr, ptr+1, ptr+2 (mod 3).
    function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        c   = p;
        for (int k = 0; k < 3; k++) begin
            if (!res[2] && v[c]) begin
                res = {1'b1, c};
            end else begin
                res = res;
            end
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
        end
        return res;
    endfunction

    function automatic logic [2:0] id2oh(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

    logic [1:0]    ptr_q, ptr_d;
    logic          crd_q, crd_d, cwr_q, cwr_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d, rdata_q, rdata_d;
    logic [2:0]    csel_q, csel_d;
    logic [2:0]    rvalid_q, rvalid_d;
    logic          t1_vld_q, t1_vld_d, t2_vld_q, t2_vld_d;
    logic [1:0]    t1_id_q, t1_id_d, t2_id_q, t2_id_d;
    logic [2:0]    pick_s;
    logic          gnt_any_s;
    logic [1:0]    gnt_id_s;

    assign pick_s    = rr_pick(req_if.valid, ptr_q);
    assign gnt_any_s = pick_s[2];
    assign gnt_id_s  = pick_s[1:0];

    // Next-state: grant decode, memory strobe/address capture and read tag advance.
    always_comb begin
        ptr_d      = ptr_q;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = csel_q;
        t1_vld_d   = 1'b0;
        t1_id_d    = t1_id_q;
        if (gnt_any_s) begin
            ptr_d  = (gnt_id_s == 2'd2) ? 2'd0 : gnt_id_s + 2'd1;
            csel_d = req_if.sel[gnt_id_s];
            if (req_if.we[gnt_id_s]) begin
                cwr_d      = 1'b1;
                caddr_wr_d = req_if.addr[gnt_id_s];
                cdata_wr_d = req_if.wdata[gnt_id_s];
            end else begin
                crd_d      = 1'b1;
                caddr_rd_d = req_if.addr[gnt_id_s];
                t1_vld_d   = 1'b1;
                t1_id_d    = gnt_id_s;
            end
        end else begin
            ptr_d = ptr_q;
        end
        t2_vld_d = t1_vld_q;
        t2_id_d  = t1_id_q;
        // Stage 2 coincides with the memory's data cycle, so capture it here.
        if (t2_vld_q) begin
            rdata_d  = cdata_rd_i;
            rvalid_d = id2oh(t2_id_q);
        end else begin
            rdata_d  = rdata_q;
            rvalid_d = 3'b000;
        end
    end

    // State registers; reset also discards any read still in the tag pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= 2'd0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= 3'd0;
            rdata_q    <= '0;
            rvalid_q   <= 3'b000;
            t1_vld_q   <= 1'b0;
            t1_id_q    <= 2'd0;
            t2_vld_q   <= 1'b0;
            t2_id_q    <= 2'd0;
        end else begin
            ptr_q      <= ptr_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            t1_vld_q   <= t1_vld_d;
            t1_id_q    <= t1_id_d;
            t2_vld_q   <= t2_vld_d;
            t2_id_q    <= t2_id_d;
        end
    end

    assign req_if.ready  = gnt_any_s ? id2oh(gnt_id_s) : 3'b000;
    assign req_if.rvalid = rvalid_q;
    assign req_if.rdata  = rdata_q;
    assign crd_o         = crd_q;
    assign cwr_o         = cwr_q;
    assign caddr_rd_o    = caddr_rd_q;
    assign caddr_wr_o    = caddr_wr_q;
    assign cdata_wr_o    = cdata_wr_q;
    assign csel_o        = csel_q;
    assign idle_o        = ~(|req_if.valid) & ~t1_vld_q & ~t2_vld_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter: expected read returns go into a scoreboard
// queue at issue time and a negedge monitor pops them when the DUT raises rvalid.
module tb_layer_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crd, cwr, idle;
    logic [11:0] caddr_rd, caddr_wr;
    logic [19:0] cdata_wr;
    logic [19:0] cdata_rd = 20'h0;
    logic [2:0]  csel;
    logic [19:0] mem [0:32767];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    typedef struct {
        int          id;
        logic [19:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    layer_mem_arbiter_if #(.AW(12), .DW(20)) bus ();

    layer_mem_arbiter #(.AW(12), .DW(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_if     (bus),
        .crd_o      (crd),
        .caddr_rd_o (caddr_rd),
        .cwr_o      (cwr),
        .caddr_wr_o (caddr_wr),
        .cdata_wr_o (cdata_wr),
        .csel_o     (csel),
        .cdata_rd_i (cdata_rd),
        .idle_o     (idle)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Layer memory keyed by {sel, addr}; read data appears the cycle after crd.
    always @(posedge clk) begin
        if (rst) mem[{3'd1, 12'h0A5}] <= 20'h12345;
        else if (cwr) mem[{csel, caddr_wr}] <= cdata_wr;
        if (crd) cdata_rd <= mem[{csel, caddr_rd}];
    end

    // Scoreboard monitor: every rvalid must match the oldest expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rvalid != 3'b000) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rvalid_unexpected actual rvalid=%b rdata=%h cyc=%0d required no rvalid",
                         bus.rvalid, bus.rdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.rvalid !== (3'b001 << e.id) || bus.rdata !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL rvalid_sb actual rvalid=%b rdata=%h cyc=%0d required rvalid=%b rdata=%h cyc=%0d",
                             bus.rvalid, bus.rdata, cyc, 3'b001 << e.id, e.data, e.due);
                end
            end
        end else if (!rst && exp_q.size() > 0 && exp_q[0].due < cyc) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("FAIL rvalid_missing actual none by cyc=%0d required id=%0d rdata=%h cyc=%0d",
                     cyc, e.id, e.data, e.due);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic we, input logic [2:0] sel,
                           input logic [11:0] addr, input logic [19:0] wd);
        bus.valid[n] = 1'b1;
        bus.we[n]    = we;
        bus.sel[n]   = sel;
        bus.addr[n]  = addr;
        bus.wdata[n] = wd;
    endtask

    task automatic push_exp(input int id, input logic [19:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.due  = cyc + 3;
        exp_q.push_back(e);
    endtask

    task automatic clr_all();
        bus.valid = 3'b000;
        bus.we    = 3'b000;
        bus.sel   = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    initial begin
        logic [2:0] fair_exp [5];
        fair_exp = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001};
        clr_all();

        // Reset state
        @(negedge clk);
        chk("rst_crd", {31'd0, crd}, 32'd0);
        chk("rst_cwr", {31'd0, cwr}, 32'd0);
        chk("rst_caddr_rd", {20'd0, caddr_rd}, 32'd0);
        chk("rst_caddr_wr", {20'd0, caddr_wr}, 32'd0);
        chk("rst_cdata_wr", {12'd0, cdata_wr}, 32'd0);
        chk("rst_csel", {29'd0, csel}, 32'd0);
        chk("rst_rdata", {12'd0, bus.rdata}, 32'd0);
        chk("rst_rvalid", {29'd0, bus.rvalid}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_ready", {29'd0, bus.ready}, 32'd0);

        // Single read by req1
        step();
        set_req(1, 1'b0, 3'd1, 12'h0A5, 20'h0);
        @(negedge clk);
        chk("rd_ready", {29'd0, bus.ready}, 32'b010);
        push_exp(1, 20'h12345);
        step();
        bus.valid[1] = 1'b0;
        @(negedge clk);
        chk("rd_crd", {31'd0, crd}, 32'd1);
        chk("rd_cwr", {31'd0, cwr}, 32'd0);
        chk("rd_caddr", {20'd0, caddr_rd}, 32'h0A5);
        chk("rd_csel", {29'd0, csel}, 32'd1);
        chk("rd_idle_busy", {31'd0, idle}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rd_idle_after", {31'd0, idle}, 32'd1);

        // Round robin from reset with all three valid
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) set_req(n, 1'b1, 3'd0, 12'h100 + 12'(n), 20'h100 + 20'(n));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_ready", {29'd0, bus.ready}, 32'(3'b001 << (i % 3)));
            if (i > 0) begin
                chk("rr_cwr", {31'd0, cwr}, 32'd1);
                chk("rr_caddr_wr", {20'd0, caddr_wr}, 32'h100 + 32'((i - 1) % 3));
                chk("rr_cdata_wr", {12'd0, cdata_wr}, 32'h100 + 32'((i - 1) % 3));
            end
            step();
        end
        clr_all();
        @(negedge clk);
        chk("rr_last_wr", {20'd0, caddr_wr}, 32'h102);

        // Write then read of the same address on consecutive edges
        step();
        set_req(0, 1'b1, 3'd0, 12'h010, 20'h00FFF);
        @(negedge clk);
        chk("wr_rd_ready0", {29'd0, bus.ready}, 32'b001);
        step();
        clr_all();
        set_req(2, 1'b0, 3'd0, 12'h010, 20'h0);
        @(negedge clk);
        chk("wr_rd_ready2", {29'd0, bus.ready}, 32'b100);
        chk("wr_rd_cwr", {31'd0, cwr}, 32'd1);
        push_exp(2, 20'h00FFF);
        step();
        clr_all();
        @(negedge clk);
        chk("wr_rd_crd", {31'd0, crd}, 32'd1);
        chk("wr_rd_caddr", {20'd0, caddr_rd}, 32'h010);
        repeat (2) @(negedge clk);

        // Fairness: req0 always valid, req2 joins once ptr has moved to 1
        step();
        set_req(0, 1'b1, 3'd0, 12'h020, 20'h1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) set_req(2, 1'b1, 3'd0, 12'h022, 20'h2);
            @(negedge clk);
            chk("fair_ready", {29'd0, bus.ready}, {29'd0, fair_exp[i]});
            step();
        end
        clr_all();

        // Alternating write/read from req1, each read returns the preceding write
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) set_req(1, 1'b1, 3'd3, 12'h200 + 12'(i), 20'h0A000 + 20'(i));
            else            set_req(1, 1'b0, 3'd3, 12'h200 + 12'(i - 1), 20'h0);
            @(negedge clk);
            chk("alt_ready", {29'd0, bus.ready}, 32'b010);
            if (i % 2 == 1) push_exp(1, 20'h0A000 + 20'(i - 1));
            if (i > 0) begin
                chk("alt_crd", {31'd0, crd}, 32'((i - 1) % 2));
                chk("alt_cwr", {31'd0, cwr}, 32'(1 - ((i - 1) % 2)));
            end
            step();
        end
        clr_all();
        @(negedge clk);
        chk("alt_last_crd", {31'd0, crd}, 32'd1);
        chk("alt_last_cwr", {31'd0, cwr}, 32'd0);
        repeat (3) @(negedge clk);

        // Reset while a read is in flight: its rvalid must never appear
        step();
        set_req(1, 1'b0, 3'd1, 12'h0A5, 20'h0);
        step();
        clr_all();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_fly_rdata", {12'd0, bus.rdata}, 32'd0);
        chk("rst_fly_crd", {31'd0, crd}, 32'd0);
        step();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_fly_idle", {31'd0, idle}, 32'd1);

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_mem_arbiter.md
# layer_mem_arbiter

Round-robin arbiter sharing the single layer-memory port (csel/crd/cwr) of the CNN accelerator among three requesters: conv/ReLU writeback (req0), max-pool (req1) and flatten (req2). It accepts at most one access per cycle and drives registered memory-side strobes. Read data returns to the issuing requester with a fixed latency. It sits between the layer engines and the external layer memory, replacing per-engine direct port driving.

## Interface
- AW, 12, memory address width (64x64 = 4096 words)
- DW, 20, memory data width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- reqN_valid  in  1  (N=0..2) requester N has an access pending
- reqN_we  in  1  1 = write, 0 = read
- reqN_sel  in  3  target memory select, passed to csel
- reqN_addr  in  AW  word address
- reqN_wdata  in  DW  write data, ignored for reads
- reqN_ready  out  1  combinational grant; access accepted at the edge where valid&ready=1
- reqN_rvalid  out  1  read data for requester N valid this cycle
- rdata  out  DW  shared registered read data, meaningful only with some reqN_rvalid
- crd  out  1  memory read strobe
- caddr_rd  out  AW  memory read address
- cwr  out  1  memory write strobe
- caddr_wr  out  AW  memory write address
- cdata_wr  out  DW  memory write data
- csel  out  3  memory select
- cdata_rd  in  DW  memory read data, valid the cycle after crd
- idle  out  1  no accepted read still in flight and no valid request

## Operation
- Round-robin pointer ptr (2 bits, values 0..2, reset 0). Search order ptr, ptr+1, ptr+2 (mod 3); first valid requester gets ready=1; all others ready=0.
- On acceptance of requester g: ptr <= (g+1) mod 3. No acceptance: ptr holds.
- readys depend only on reqN_valid and ptr; requesters must not make valid depend on ready. Valid may drop without acceptance; arbiter keeps no state for it.
- Accepted write: next cycle cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
- Accepted read: next cycle crd=1, caddr_rd=addr, csel=sel, cwr=0.
- No acceptance: next cycle crd=0, cwr=0; caddr_rd, caddr_wr, cdata_wr, csel hold last values.
- Read tag pipeline: 2 stages carrying {valid, owner id}. Stage1 loaded at acceptance edge, stage2 at next edge; stage2 captures cdata_rd into rdata and asserts reqN_rvalid for owner only. Never more than one rvalid high.
- Memory strictly in order: a write accepted at edge E and a read of the same address accepted at E+1 return the new data.
- idle = no reqN_valid and both tag stages empty.

## Timing
- Reset (async, immediate): ptr=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, csel=0, rdata=0, all rvalid=0, tag stages empty, idle=1 once reset released with no valid. In-flight reads at reset are discarded; no rvalid after reset release for them.
- Accept at edge E0 -> strobe visible cycle E0..E1 -> memory returns cdata_rd cycle E1..E2 -> rvalid/rdata cycle E2..E3. Read latency = 2 cycles after acceptance edge.
- Throughput: one access per cycle, sustained; reads and writes freely interleaved, read data pipelined back-to-back.
- Fairness: continuously valid requester waits at most 2 accepted cycles.
- Strobes are single-cycle per access; consecutive accesses give continuous strobes.

## Test plan
- Reset with all valid=0 -> all outputs 0, idle=1, ready all 0; assert reset while read in flight -> no rvalid ever appears for it.
- req1 read addr 0x0A5, sel=1, memory model returns 0x12345 -> crd=1, caddr_rd=0x0A5, csel=1 one cycle after accept; req1_rvalid=1, rdata=0x12345 exactly 2 cycles after accept; req0/req2 rvalid stay 0.
- All three valid continuously from reset -> grant order 0,1,2,0,1,2; each ready high exactly one cycle in three.
- req0 writes 0x00FFF to addr 0x010 at edge E, req2 reads 0x010 at E+1 -> req2_rvalid with rdata=0x00FFF at E+3.
- req0 valid continuously, req2 raises valid when ptr=1 with req1 idle -> req2 granted next cycle, then req0; req0 never starved more than 2 cycles.
- Alternating read/write from req1 for 8 cycles -> crd/cwr alternate every cycle, never both high; 4 rvalids in order with correct data.
